// File: rtl/parking_gate_ctrl.sv
// Car-park lane controller: keypad-gated entry barrier with retry lockout and
// entry timeout, an independent exit barrier, and an occupancy counter.
//
// Entry FSM states:
//   state   | meaning
//   IDLE    | lane empty or car waiting while the park is full
//   WAIT_PW | car at entry, waiting for keypad code
//   OPEN_IN | code accepted, entry barrier raised until car passes
//   LOCKED  | too many wrong codes, lane ignored for LOCK_CYCLES cycles
module parking_gate_ctrl #(
  parameter int                   PW_WIDTH     = 4,
  parameter logic [PW_WIDTH-1:0]  PASSWORD     = 4'b0110,
  parameter int                   MAX_ATTEMPTS = 3,
  parameter int                   CAPACITY     = 8,
  parameter int                   PW_TIMEOUT   = 16,
  parameter int                   LOCK_CYCLES  = 32,
  parameter int                   CNT_W        = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sensor_entrance,
  input  logic                sensor_exit,
  input  logic                pw_valid,
  input  logic [PW_WIDTH-1:0] pw_code,
  output logic                gate_in_open,
  output logic                gate_out_open,
  output logic                green,
  output logic                red,
  output logic                full,
  output logic                lockout,
  output logic [CNT_W-1:0]    occupancy,
  output logic [3:0]          attempts_left
);

  // Timers count down from (duration-1) to a terminal count of zero.
  localparam int PT_W = (PW_TIMEOUT > 2) ? $clog2(PW_TIMEOUT) : 1;
  localparam int LT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [PT_W-1:0]  PT_LOAD  = PT_W'(PW_TIMEOUT - 1);
  localparam logic [LT_W-1:0]  LT_LOAD  = LT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [3:0]       ATT_LOAD = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PW = 2'd1,
    OPEN_IN = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PT_W-1:0]  pw_tmr_q, pw_tmr_d;
  logic [LT_W-1:0]  lock_tmr_q, lock_tmr_d;
  logic [3:0]       attempts_left_q, attempts_left_d;
  logic             gate_in_open_q, gate_in_open_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             lockout_q, lockout_d;
  logic             gate_out_open_q, gate_out_open_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             full_q, full_d;
  logic             sensor_exit_q;

  logic entry_done;
  logic exit_done;
  logic exit_rise;
  logic exit_fall;

  assign exit_rise = sensor_exit & ~sensor_exit_q;
  assign exit_fall = ~sensor_exit & sensor_exit_q;

  // Entry FSM next state, timers, retry count and entry-side lamp/barrier outputs.
  always_comb begin
    state_d         = state_q;
    pw_tmr_d        = pw_tmr_q;
    lock_tmr_d      = lock_tmr_q;
    attempts_left_d = attempts_left_q;
    entry_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sensor_entrance && !full_q) begin
          state_d         = WAIT_PW;
          attempts_left_d = ATT_LOAD;
          pw_tmr_d        = PT_LOAD;
        end
      end
      WAIT_PW: begin
        // A keypad entry wins over an expiring timeout in the same cycle.
        if (pw_valid) begin
          if (pw_code == PASSWORD) begin
            state_d = OPEN_IN;
          end else begin
            attempts_left_d = attempts_left_q - 4'd1;
            pw_tmr_d        = PT_LOAD;
            if (attempts_left_q == 4'd1) begin
              state_d    = LOCKED;
              lock_tmr_d = LT_LOAD;
            end
          end
        end else if (pw_tmr_q == '0) begin
          state_d         = IDLE;
          attempts_left_d = 4'd0;
        end else begin
          pw_tmr_d = pw_tmr_q - PT_W'(1);
        end
      end
      OPEN_IN: begin
        if (!sensor_entrance) begin
          entry_done = 1'b1;
          state_d    = IDLE;
        end
      end
      LOCKED: begin
        if (lock_tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_tmr_d = lock_tmr_q - LT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    gate_in_open_d = (state_d == OPEN_IN);
    green_d        = (state_d == OPEN_IN);
    lockout_d      = (state_d == LOCKED);
    // Red also shows a waiting car that is refused because the park is full.
    red_d          = (state_d == WAIT_PW) || (state_d == LOCKED) ||
                     ((state_q == IDLE) && (state_d == IDLE) && sensor_entrance && full_q);
  end

  // Exit barrier and occupancy bookkeeping; exits only count when the gate opened.
  always_comb begin
    gate_out_open_d = gate_out_open_q;
    exit_done       = 1'b0;
    if (exit_rise && (occupancy_q != '0)) begin
      gate_out_open_d = 1'b1;
    end else if (exit_fall && gate_out_open_q) begin
      gate_out_open_d = 1'b0;
      exit_done       = 1'b1;
    end

    occupancy_d = occupancy_q;
    if (entry_done && !exit_done) begin
      if (occupancy_q != CAP) occupancy_d = occupancy_q + CNT_W'(1);
    end else if (exit_done && !entry_done) begin
      if (occupancy_q != '0) occupancy_d = occupancy_q - CNT_W'(1);
    end

    full_d = (occupancy_d == CAP);
  end

  // All state and outputs are registered; reset closes both barriers at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      pw_tmr_q        <= '0;
      lock_tmr_q      <= '0;
      attempts_left_q <= 4'd0;
      gate_in_open_q  <= 1'b0;
      green_q         <= 1'b0;
      red_q           <= 1'b0;
      lockout_q       <= 1'b0;
      gate_out_open_q <= 1'b0;
      occupancy_q     <= '0;
      full_q          <= 1'b0;
      sensor_exit_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pw_tmr_q        <= pw_tmr_d;
      lock_tmr_q      <= lock_tmr_d;
      attempts_left_q <= attempts_left_d;
      gate_in_open_q  <= gate_in_open_d;
      green_q         <= green_d;
      red_q           <= red_d;
      lockout_q       <= lockout_d;
      gate_out_open_q <= gate_out_open_d;
      occupancy_q     <= occupancy_d;
      full_q          <= full_d;
      sensor_exit_q   <= sensor_exit;
    end
  end

  assign gate_in_open  = gate_in_open_q;
  assign gate_out_open = gate_out_open_q;
  assign green         = green_q;
  assign red           = red_q;
  assign full          = full_q;
  assign lockout       = lockout_q;
  assign occupancy     = occupancy_q;
  assign attempts_left = attempts_left_q;

endmodule
